// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC lane group and its
// downstream output-feature-map collector.
//
// Contents:
//   MAC_LANE_GROUP        number of MAC lanes in a group (8)
//   MAC_OFM_FIFO_DEPTH    default per-lane collector FIFO depth (4)
//   MAC_OFM_W_BEAT_COUNT  width of the per-tile beat counter (16)
//   mac_lane_ofm_port     one lane output word: 32-bit data + output_end
//   mac_lane_monitor      per-lane NaN/Inf flags
//   mac_ofm_beat          one aligned collector beat for a full lane group
//   mac_ofm_next_beat_count  per-tile beat counter update rule
package mac_pkg;

  localparam int MAC_LANE_GROUP       = 8;
  localparam int MAC_OFM_FIFO_DEPTH   = 4;
  localparam int MAC_OFM_W_BEAT_COUNT = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        output_end;
  } mac_lane_ofm_port;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
  } mac_lane_monitor;

  typedef struct packed {
    logic [32*MAC_LANE_GROUP-1:0] data;
    logic                         output_end;
  } mac_ofm_beat;

  // The counter restarts at the last beat of a tile and otherwise sticks at
  // all-ones rather than wrapping, so an overlong tile is still recognisable.
  function automatic logic [MAC_OFM_W_BEAT_COUNT-1:0] mac_ofm_next_beat_count(
    input logic [MAC_OFM_W_BEAT_COUNT-1:0] cur,
    input logic                            is_end
  );
    if (is_end) begin
      return '0;
    end
    if (&cur) begin
      return cur;
    end
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/mac_ofm_fifo.sv
// mac_ofm_fifo: single-clock FIFO of mac_lane_ofm_port words, one per lane
// of the collector.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   push, wr_word write request and the word to store
//   pop           remove the head word
//   head_word     word currently at the head (valid when !empty)
//   full, empty   occupancy flags
//   count         number of stored words, 0..DEPTH
//
// DEPTH must be a power of two and at least 2 so the pointers wrap
// naturally and count needs exactly one extra bit.
module mac_ofm_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = MAC_OFM_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  mac_lane_ofm_port           wr_word,
  input  logic                       pop,
  output mac_lane_ofm_port           head_word,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  mac_lane_ofm_port mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push_ok;
  logic             pop_ok;

  // Requests against a full or empty FIFO are dropped so a misbehaving
  // neighbour can never corrupt the pointers.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage carries no reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Pointers wrap at DEPTH; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_word = mem[rd_ptr];
  assign full      = (cnt == FULL_COUNT);
  assign empty     = (cnt == '0);
  assign count     = cnt;

endmodule

// File: rtl/mac_ofm_collector.sv
// mac_ofm_collector: gathers one word from every MAC lane into an aligned
// output beat. Each lane is buffered in its own mac_ofm_fifo; when every
// FIFO has a head word they are all popped together into a single output
// register presented on a valid/ready handshake. Lanes that disagree on
// output_end raise a sticky error, and beats are counted per tile.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   i_lane_ofm        per-lane data word + output_end
//   i_lane_valid      per-lane word valid
//   o_lane_ready      per-lane ready (lane FIFO not full, registered state only)
//   o_ofm_data        output beat, lane k at bits [32k+31:32k]
//   o_ofm_end         beat is the last of its tile
//   o_ofm_valid       beat valid
//   i_ofm_ready       consumer accepts the beat
//   o_beat_count      beats accepted so far in the current tile
//   o_end_mismatch    sticky: lanes disagreed on output_end at a gather
//
// Optional feature, macro MAC_OFM_MONITOR_EN:
//   i_lane_monitor    per-lane NaN/Inf flags, qualified by an accepted push
//   i_monitor_clear   clears the sticky monitor flags (a same-cycle set wins)
//   o_monitor_nan     sticky: some accepted push carried is_nan
//   o_monitor_inf     sticky: some accepted push carried is_inf
module mac_ofm_collector
  import mac_pkg::*;
#(
  parameter int LANES      = MAC_LANE_GROUP,
  parameter int FIFO_DEPTH = MAC_OFM_FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  mac_lane_ofm_port [LANES-1:0]        i_lane_ofm,
  input  logic [LANES-1:0]                    i_lane_valid,
  output logic [LANES-1:0]                    o_lane_ready,
`ifdef MAC_OFM_MONITOR_EN
  input  mac_lane_monitor [LANES-1:0]         i_lane_monitor,
  input  logic                                i_monitor_clear,
  output logic                                o_monitor_nan,
  output logic                                o_monitor_inf,
`endif
  output logic [32*LANES-1:0]                 o_ofm_data,
  output logic                                o_ofm_end,
  output logic                                o_ofm_valid,
  input  logic                                i_ofm_ready,
  output logic [MAC_OFM_W_BEAT_COUNT-1:0]     o_beat_count,
  output logic                                o_end_mismatch
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mac_lane_ofm_port [LANES-1:0] head_word;
  logic [LANES-1:0]             lane_push;
  logic [LANES-1:0]             lane_full;
  logic [LANES-1:0]             lane_empty;
  logic [CW-1:0]                lane_count [LANES];

  logic                         all_head;
  logic                         load;
  logic                         handshake;
  logic [32*LANES-1:0]          gathered_data;
  logic                         heads_any_end;
  logic                         heads_all_end;

  // One FIFO per lane. Ready comes from the registered occupancy count only,
  // so a pop in the same cycle never opens a slot early and o_lane_ready has
  // no path from i_ofm_ready or any other input.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_ofm_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (lane_push[k]),
      .wr_word   (i_lane_ofm[k]),
      .pop       (load),
      .head_word (head_word[k]),
      .full      (lane_full[k]),
      .empty     (lane_empty[k]),
      .count     (lane_count[k])
    );

    assign o_lane_ready[k] = (lane_count[k] < CW'(FIFO_DEPTH));
    assign lane_push[k]    = i_lane_valid[k] & ~lane_full[k];
  end

  // A beat can only form once every lane has a head word; all lanes then pop
  // together, never individually. The output register takes the new beat when
  // it is empty or its current beat is leaving this cycle.
  assign all_head  = ~|lane_empty;
  assign load      = all_head & (~o_ofm_valid | i_ofm_ready);
  assign handshake = o_ofm_valid & i_ofm_ready;

  // Lay the head words side by side and summarise their end flags: any-set
  // drives o_ofm_end, while any-set differing from all-set means disagreement.
  always_comb begin
    gathered_data = '0;
    heads_any_end = 1'b0;
    heads_all_end = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      gathered_data[32*k +: 32] = head_word[k].data;
      heads_any_end = heads_any_end | head_word[k].output_end;
      heads_all_end = heads_all_end & head_word[k].output_end;
    end
  end

  // Output register: holds its beat stable under backpressure and drops
  // valid once the beat is taken with nothing new to replace it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ofm_valid <= 1'b0;
      o_ofm_data  <= '0;
      o_ofm_end   <= 1'b0;
    end else if (load) begin
      o_ofm_valid <= 1'b1;
      o_ofm_data  <= gathered_data;
      o_ofm_end   <= heads_any_end;
    end else if (handshake) begin
      o_ofm_valid <= 1'b0;
    end
  end

  // The mismatch flag only ever sets; clearing it takes a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_end_mismatch <= 1'b0;
    end else if (load && (heads_any_end != heads_all_end)) begin
      o_end_mismatch <= 1'b1;
    end
  end

  // Beats are counted when the consumer actually takes them, not when they
  // are gathered, so the count reflects delivered beats in the tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_beat_count <= '0;
    end else if (handshake) begin
      o_beat_count <= mac_ofm_next_beat_count(o_beat_count, o_ofm_end);
    end
  end

`ifdef MAC_OFM_MONITOR_EN
  logic nan_seen;
  logic inf_seen;

  // Only words actually accepted into a FIFO contribute to the monitors.
  always_comb begin
    nan_seen = 1'b0;
    inf_seen = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      nan_seen = nan_seen | (lane_push[k] & i_lane_monitor[k].is_nan);
      inf_seen = inf_seen | (lane_push[k] & i_lane_monitor[k].is_inf);
    end
  end

  // Sticky flags; a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_monitor_nan <= 1'b0;
      o_monitor_inf <= 1'b0;
    end else begin
      if (nan_seen) begin
        o_monitor_nan <= 1'b1;
      end else if (i_monitor_clear) begin
        o_monitor_nan <= 1'b0;
      end
      if (inf_seen) begin
        o_monitor_inf <= 1'b1;
      end else if (i_monitor_clear) begin
        o_monitor_inf <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_ofm_collector.sv
// tb_mac_ofm_collector: directed self-checking bench for mac_ofm_collector.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, so every observation reflects the last edge.
module tb_mac_ofm_collector;
  import mac_pkg::*;

  localparam int LANES = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  mac_lane_ofm_port [LANES-1:0]  lane_ofm;
  logic [LANES-1:0]              lane_valid;
  logic [LANES-1:0]              lane_ready;
  logic [32*LANES-1:0]           ofm_data;
  logic                          ofm_end;
  logic                          ofm_valid;
  logic                          ofm_ready;
  logic [15:0]                   beat_count;
  logic                          end_mismatch;
`ifdef MAC_OFM_MONITOR_EN
  mac_lane_monitor [LANES-1:0]   lane_monitor;
  logic                          monitor_clear;
  logic                          monitor_nan;
  logic                          monitor_inf;
`endif

  int checks   = 0;
  int failures = 0;
  int pushed;

  always #5 clk = ~clk;

  mac_ofm_collector #(
    .LANES      (LANES),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_lane_ofm     (lane_ofm),
    .i_lane_valid   (lane_valid),
    .o_lane_ready   (lane_ready),
`ifdef MAC_OFM_MONITOR_EN
    .i_lane_monitor (lane_monitor),
    .i_monitor_clear(monitor_clear),
    .o_monitor_nan  (monitor_nan),
    .o_monitor_inf  (monitor_inf),
`endif
    .o_ofm_data     (ofm_data),
    .o_ofm_end      (ofm_end),
    .o_ofm_valid    (ofm_valid),
    .i_ofm_ready    (ofm_ready),
    .o_beat_count   (beat_count),
    .o_end_mismatch (end_mismatch)
  );

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected beat: lane k carries base + k.
  function automatic logic [32*LANES-1:0] expData(input logic [31:0] base);
    logic [32*LANES-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      v[32*k +: 32] = base + 32'(k);
    end
    return v;
  endfunction

  task automatic driveLanes(input logic [LANES-1:0] mask, input logic [31:0] base,
                            input logic [LANES-1:0] end_mask);
    lane_valid = mask;
    for (int k = 0; k < LANES; k++) begin
      lane_ofm[k].data       = base + 32'(k);
      lane_ofm[k].output_end = end_mask[k];
    end
  endtask

  // Present one word on the masked lanes for exactly one cycle.
  task automatic applyStimulus(input logic [LANES-1:0] mask, input logic [31:0] base,
                               input logic [LANES-1:0] end_mask);
    driveLanes(mask, base, end_mask);
    step();
    lane_valid = '0;
  endtask

  // Wait (bounded) for a beat, check it, then let it be consumed.
  task automatic expectBeat(input string tag, input logic [31:0] base,
                            input logic exp_end, input int exp_count);
    int n;
    n = 0;
    while (!ofm_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, "_valid"}, 256'(ofm_valid), 256'(1));
    checkOutput({tag, "_data"},  256'(ofm_data),  256'(expData(base)));
    checkOutput({tag, "_end"},   256'(ofm_end),   256'(exp_end));
    checkOutput({tag, "_count"}, 256'(beat_count), 256'(exp_count));
    step();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"},    256'(ofm_valid),    256'(0));
    checkOutput({tag, "_end"},      256'(ofm_end),      256'(0));
    checkOutput({tag, "_data"},     256'(ofm_data),     256'(0));
    checkOutput({tag, "_count"},    256'(beat_count),   256'(0));
    checkOutput({tag, "_mismatch"}, 256'(end_mismatch), 256'(0));
    checkOutput({tag, "_ready"},    256'(lane_ready),   256'(8'hFF));
`ifdef MAC_OFM_MONITOR_EN
    checkOutput({tag, "_nan"},      256'(monitor_nan),  256'(0));
    checkOutput({tag, "_inf"},      256'(monitor_inf),  256'(0));
`endif
  endtask

  initial begin
    rst        = 1'b1;
    ofm_ready  = 1'b1;
    lane_valid = '0;
    lane_ofm   = '0;
`ifdef MAC_OFM_MONITOR_EN
    lane_monitor  = '0;
    monitor_clear = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;
    checkResetState("reset");

    // Single beat: pushed in cycle 0, visible in cycle 2, counted on handshake.
    applyStimulus(8'hFF, 32'h1000, 8'h00);
    checkOutput("single_c1_valid", 256'(ofm_valid), 256'(0));
    step();
    checkOutput("single_c2_valid", 256'(ofm_valid), 256'(1));
    expectBeat("single", 32'h1000, 1'b0, 0);
    checkOutput("single_count_after", 256'(beat_count), 256'(1));
    checkOutput("single_valid_after", 256'(ofm_valid),  256'(0));

    // Staggered: lanes 0-6 at cycle 0, lane 7 at cycle 5, beat in cycle 7.
    for (int c = 0; c <= 6; c++) begin
      applyStimulus((c == 0) ? 8'h7F : (c == 5) ? 8'h80 : 8'h00, 32'h2000, 8'h00);
      checkOutput($sformatf("stagger_c%0d_valid", c + 1), 256'(ofm_valid),
                  256'(c == 6));
    end
    expectBeat("stagger", 32'h2000, 1'b0, 1);

    // Backpressure: consumer stalls 10 cycles while all lanes push.
    ofm_ready = 1'b0;
    pushed    = 0;
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("bp_c%0d_ready", c), 256'(lane_ready),
                  256'((c < 5) ? 8'hFF : 8'h00));
      driveLanes(8'hFF, 32'h3000 + 32'(pushed << 4), 8'h00);
      if (lane_ready[0]) begin
        pushed++;
      end
      step();
      if (c >= 1) begin
        checkOutput($sformatf("bp_c%0d_hold_valid", c + 1), 256'(ofm_valid), 256'(1));
        checkOutput($sformatf("bp_c%0d_hold_data", c + 1), 256'(ofm_data),
                    256'(expData(32'h3000)));
      end
    end
    lane_valid = '0;
    ofm_ready  = 1'b1;
    checkOutput("bp_pushed", 256'(pushed), 256'(5));
    for (int j = 0; j < 5; j++) begin
      expectBeat($sformatf("bp_drain%0d", j), 32'h3000 + 32'(j << 4), 1'b0, 2 + j);
    end
    checkOutput("bp_count_after", 256'(beat_count), 256'(7));

    // Reset with two words queued in lanes 0-3.
    applyStimulus(8'h0F, 32'h4000, 8'h00);
    applyStimulus(8'h0F, 32'h4010, 8'h00);
    rst = 1'b1;
    step();
    checkResetState("midrst");
    rst = 1'b0;
    applyStimulus(8'hF0, 32'h5000, 8'hFF);
    step();
    checkOutput("midrst_no_stale_beat", 256'(ofm_valid), 256'(0));
    applyStimulus(8'h0F, 32'h5000, 8'hFF);
    expectBeat("post_rst", 32'h5000, 1'b1, 0);
    checkOutput("post_rst_count", 256'(beat_count), 256'(0));

    // Tile end: three beats queued under stall, third carries end on all lanes.
    ofm_ready = 1'b0;
    applyStimulus(8'hFF, 32'h6000, 8'h00);
    applyStimulus(8'hFF, 32'h6100, 8'h00);
    applyStimulus(8'hFF, 32'h6200, 8'hFF);
    ofm_ready = 1'b1;
    expectBeat("tile0", 32'h6000, 1'b0, 0);
    expectBeat("tile1", 32'h6100, 1'b0, 1);
    expectBeat("tile2", 32'h6200, 1'b1, 2);
    checkOutput("tile_count_after", 256'(beat_count), 256'(0));
    checkOutput("tile_no_mismatch", 256'(end_mismatch), 256'(0));

    // End mismatch: only lane 3 flags end.
    applyStimulus(8'hFF, 32'h7000, 8'h08);
    expectBeat("mm", 32'h7000, 1'b1, 0);
    checkOutput("mm_set", 256'(end_mismatch), 256'(1));
    applyStimulus(8'hFF, 32'h7100, 8'h00);
    expectBeat("mm_next", 32'h7100, 1'b0, 0);
    checkOutput("mm_sticky", 256'(end_mismatch), 256'(1));

`ifdef MAC_OFM_MONITOR_EN
    // Lane 5 pushes an Inf word; the flag sets, then a clear removes it.
    lane_monitor[5].is_inf = 1'b1;
    applyStimulus(8'h20, 32'h7200, 8'h00);
    lane_monitor = '0;
    checkOutput("mon_inf_set", 256'(monitor_inf), 256'(1));
    checkOutput("mon_nan_clear", 256'(monitor_nan), 256'(0));
    monitor_clear = 1'b1;
    step();
    monitor_clear = 1'b0;
    checkOutput("mon_inf_cleared", 256'(monitor_inf), 256'(0));
`endif

    // Final reset clears the sticky error and any partial lane contents.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkResetState("final_rst");
    applyStimulus(8'hFF, 32'h8000, 8'h00);
    expectBeat("final_beat", 32'h8000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
